hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the RV32 core. It is the successor to the fixed 2-port, 3-source forwarding logic. It generates per-operand forwarding selects for NUM_RS read ports from NUM_FWD prioritised producer stages. It also adds what the fixed logic lacks: a registered load-use stall FSM with configurable load latency, and branch-redirect flush control. It sits beside the ID/EX pipeline registers. Its outputs drive the EX operand muxes and the IF/ID/EX stall and flush enables.

Parameters:
NUM_RS, 2, number of source-operand read ports (1..4)
NUM_FWD, 3, number of forwarding sources; index 0 is the youngest and has the highest priority (1..7)
LD_LAT, 1, bubble cycles required between a load in EX and a dependent consumer (1..4)
REG_AW, 5, register address width
SELW, derived $clog2(NUM_FWD+1), width of one forwarding select

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ex_rs_addr  in  NUM_RS*REG_AW  source addresses of the instruction in EX (port i at slice i)
id_rs_addr  in  NUM_RS*REG_AW  source addresses of the instruction in ID
id_rs_used  in  NUM_RS  ID instruction actually reads port i
fwd_wr  in  NUM_FWD  producer j writes the register file
fwd_rd  in  NUM_FWD*REG_AW  destination of producer j
ex_is_load  in  1  EX instruction is a load
ex_rd_wr  in  1  EX instruction writes rd
ex_rd  in  REG_AW  EX destination
redirect  in  1  taken branch/jump resolved in EX
fwd_sel  out  NUM_RS*SELW  per port: 0 = register file, j+1 = producer j
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  clear IF/ID to NOP
flush_ex  out  1  clear ID/EX to NOP (bubble)
busy  out  1  FSM not in IDLE

Behaviour:
- Forwarding (combinational):
  - For each port i, fwd_sel[i] = j+1 for the lowest j with fwd_wr[j] && fwd_rd[j]!=0 && fwd_rd[j]==ex_rs_addr[i].
  - If no producer matches, fwd_sel[i] = 0.
  - Address 0 never forwards.
  - fwd_sel is forced to 0 when rst_n==0.
- Load-use detect (combinational): lu_hit = ex_is_load && ex_rd_wr && ex_rd!=0 && OR over i of (id_rs_used[i] && id_rs_addr[i]==ex_rd).
- FSM states: IDLE and LU_STALL. The registered counter cnt is $clog2(LD_LAT+1) bits wide.
- IDLE:
  - If redirect: flush_id=1, flush_ex=1, no stall, stay in IDLE.
  - Else if lu_hit: stall_if=1, stall_id=1, flush_ex=1 in the same cycle.
    - If LD_LAT>1: next state LU_STALL, cnt <= LD_LAT-1.
    - Otherwise stay in IDLE.
  - Otherwise all control outputs are 0.
- LU_STALL:
  - stall_if=1, stall_id=1, flush_ex=1, busy=1.
  - cnt decrements each cycle. When cnt==1, next state is IDLE and cnt <= 0.
  - lu_hit is not re-evaluated in this state. EX holds a bubble.
- Redirect priority:
  - redirect in any state wins.
  - Outputs: flush_id=1, flush_ex=1, stall_if=0, stall_id=0.
  - next state IDLE, cnt <= 0.
- Outputs are combinational from state and inputs. Only state and cnt are registered.
- Reset (rst_n==0 at a rising clk):
  - state <= IDLE, cnt <= 0.
  - While rst_n==0: stall_if, stall_id, flush_id, flush_ex and busy are all forced to 0.
  - Reset mid-stall aborts the stall; the first cycle after release is IDLE.
- Total stall for one load-use = LD_LAT cycles. Back-to-back loads re-trigger from IDLE on the following cycle.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on every cycle with stall_if=1.
  - perf_flush_cnt increments on every cycle with redirect=1.
  - Both counters are cleared by synchronous reset and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - typedef enum {HZ_IDLE, HZ_LU_STALL} hz_state_e
  - localparam FWD_RF = 0
  - function fwd_sel_width(num_fwd)
- Sub-module fwd_sel_unit: one read port's priority encoder over NUM_FWD sources. It is instantiated NUM_RS times in a generate loop.

Test Plan:
1. Default params. fwd 0/1/2 all write x5, ex_rs_addr[0]=5 -> fwd_sel[0]=1. Drop fwd_wr[0] -> fwd_sel[0]=2.
2. fwd_rd[0]=0 with fwd_wr[0]=1 and ex_rs_addr[0]=0 -> fwd_sel[0]=0.
3. LD_LAT=3. Load writes x7 in EX; ID reads x7 on port 1 with id_rs_used[1]=1 -> stall_if/stall_id/flush_ex high for exactly 3 cycles; busy high in cycles 2-3; IDLE on cycle 4.
4. LD_LAT=3. redirect asserted in the 2nd stall cycle -> that cycle: flush_id=1, flush_ex=1, stall=0; next cycle IDLE, busy=0.
5. Load-use with id_rs_used=0 -> no stall. Load with ex_rd=0 -> no stall.
6. rst_n low mid LU_STALL -> all control outputs 0; after release, state IDLE. With HAZARD_PERF_EN, perf counters read 0 after reset and perf_stall_cnt==LD_LAT after one load-use event.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32 hazard controller.
package hazard_pkg;

    typedef enum logic {
        HZ_IDLE,
        HZ_LU_STALL
    } hz_state_e;

    localparam int FWD_RF = 0;

    function automatic int fwd_sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Priority encoder for one read port: the youngest matching producer wins.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int REG_AW  = 5,
    parameter int SELW    = 2
) (
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [NUM_FWD-1:0]        fwd_wr,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    output logic [SELW-1:0]           sel
);

    logic [REG_AW-1:0] rd;

    // Scan oldest to youngest so the lowest index overwrites last.
    always_comb begin
        sel = SELW'(FWD_RF);
        rd  = '0;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            rd = fwd_rd[j*REG_AW +: REG_AW];
            if (fwd_wr[j] && rd != '0 && rd == rs_addr) begin
                sel = SELW'(j + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding selects, load-use stall FSM and redirect flush control.
// Optional HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_RS  = 2,
    parameter int NUM_FWD = 3,
    parameter int LD_LAT  = 1,
    parameter int REG_AW  = 5,
    localparam int SELW   = fwd_sel_width(NUM_FWD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_RS*REG_AW-1:0]  ex_rs_addr,
    input  logic [NUM_RS*REG_AW-1:0]  id_rs_addr,
    input  logic [NUM_RS-1:0]         id_rs_used,
    input  logic [NUM_FWD-1:0]        fwd_wr,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic                      ex_is_load,
    input  logic                      ex_rd_wr,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      redirect,
    output logic [NUM_RS*SELW-1:0]    fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_id,
    output logic                      flush_ex,
    output logic                      busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
`endif
);

    localparam int CW = $clog2(LD_LAT + 1);

    logic [NUM_RS*SELW-1:0] sel_raw;

    for (genvar i = 0; i < NUM_RS; i++) begin : g_port
        fwd_sel_unit #(
            .NUM_FWD (NUM_FWD),
            .REG_AW  (REG_AW),
            .SELW    (SELW)
        ) u_sel (
            .rs_addr (ex_rs_addr[i*REG_AW +: REG_AW]),
            .fwd_wr  (fwd_wr),
            .fwd_rd  (fwd_rd),
            .sel     (sel_raw[i*SELW +: SELW])
        );
    end

    assign fwd_sel = rst_n ? sel_raw : '0;

    logic rs_hit;
    logic lu_hit;

    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (id_rs_used[i] && id_rs_addr[i*REG_AW +: REG_AW] == ex_rd) begin
                rs_hit = 1'b1;
            end
        end
    end

    assign lu_hit = ex_is_load && ex_rd_wr && ex_rd != '0 && rs_hit;

    hz_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            state_d = HZ_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HZ_IDLE: begin
                    if (lu_hit && LD_LAT > 1) begin
                        state_d = HZ_LU_STALL;
                        cnt_d   = CW'(LD_LAT - 1);
                    end
                end
                HZ_LU_STALL: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = HZ_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = HZ_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        busy     = 1'b0;
        if (rst_n) begin
            busy = (state_q != HZ_IDLE);
            if (redirect) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (state_q == HZ_LU_STALL || lu_hit) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_if};
        perf_flush_d = perf_flush_q + {31'd0, redirect};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random plus directed bench for hazard_ctrl at LD_LAT=3 and LD_LAT=1.
// Checks perf counters when built with HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ex_rs_addr = '0;
    logic [9:0]  id_rs_addr = '0;
    logic [1:0]  id_rs_used = '0;
    logic [2:0]  fwd_wr = '0;
    logic [14:0] fwd_rd = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_rd_wr = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        redirect = 1'b0;

    logic [3:0] sel3, sel1;
    logic si3, sd3, fi3, fe3, b3;
    logic si1, sd1, fi1, fe1, b1;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps3, pf3, ps1, pf1;
    int unsigned m_ps3, m_pf, m_ps1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int rem3 = 0;
    int rem1 = 0;
    bit inited = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.NUM_RS(2), .NUM_FWD(3), .LD_LAT(3), .REG_AW(5)) u3 (
        .clk(clk), .rst_n(rst_n),
        .ex_rs_addr(ex_rs_addr), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .fwd_wr(fwd_wr), .fwd_rd(fwd_rd),
        .ex_is_load(ex_is_load), .ex_rd_wr(ex_rd_wr), .ex_rd(ex_rd),
        .redirect(redirect), .fwd_sel(sel3),
        .stall_if(si3), .stall_id(sd3), .flush_id(fi3),
        .flush_ex(fe3), .busy(b3)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps3), .perf_flush_cnt(pf3)
`endif
    );

    hazard_ctrl #(.NUM_RS(2), .NUM_FWD(3), .LD_LAT(1), .REG_AW(5)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ex_rs_addr(ex_rs_addr), .id_rs_addr(id_rs_addr),
        .id_rs_used(id_rs_used), .fwd_wr(fwd_wr), .fwd_rd(fwd_rd),
        .ex_is_load(ex_is_load), .ex_rd_wr(ex_rd_wr), .ex_rd(ex_rd),
        .redirect(redirect), .fwd_sel(sel1),
        .stall_if(si1), .stall_id(sd1), .flush_id(fi1),
        .flush_ex(fe1), .busy(b1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: first producer index whose destination equals the port.
    function automatic int exp_sel(input int p);
        logic [4:0] a;
        logic [4:0] d;
        if (!rst_n) return 0;
        a = ex_rs_addr[p*5 +: 5];
        for (int j = 0; j < 3; j++) begin
            d = fwd_rd[j*5 +: 5];
            if (fwd_wr[j] && d != 0 && d == a) return j + 1;
        end
        return 0;
    endfunction

    function automatic bit luhit();
        bit dep = 0;
        for (int i = 0; i < 2; i++)
            if (id_rs_used[i] && id_rs_addr[i*5 +: 5] == ex_rd) dep = 1;
        return ex_is_load && ex_rd_wr && ex_rd != 0 && dep;
    endfunction

    // rem = bubble cycles still owed after the current one started.
    function automatic logic [4:0] exp_ctl(input int rem);
        if (!rst_n) return 5'b00000;
        if (redirect) return {4'b0011, rem > 0};
        if (rem > 0) return 5'b11011;
        if (luhit()) return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic int next_rem(input int rem, input int lat);
        if (!rst_n || redirect) return 0;
        if (rem > 0) return rem - 1;
        if (luhit()) return lat - 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) inited <= 1;
`ifdef HAZARD_PERF_EN
        if (!rst_n) begin
            m_ps3 <= 0;
            m_ps1 <= 0;
            m_pf  <= 0;
        end else begin
            m_ps3 <= m_ps3 + 32'(exp_ctl(rem3) >> 4);
            m_ps1 <= m_ps1 + 32'(exp_ctl(rem1) >> 4);
            m_pf  <= m_pf + 32'(redirect);
        end
`endif
        rem3 <= next_rem(rem3, 3);
        rem1 <= next_rem(rem1, 1);
    end

    always @(negedge clk) begin
        if (inited) begin
            for (int p = 0; p < 2; p++) begin
                chk("fwd_sel_lat3", 32'(sel3[p*2 +: 2]), 32'(exp_sel(p)));
                chk("fwd_sel_lat1", 32'(sel1[p*2 +: 2]), 32'(exp_sel(p)));
            end
            chk("ctl_lat3", 32'({si3, sd3, fi3, fe3, b3}), 32'(exp_ctl(rem3)));
            chk("ctl_lat1", 32'({si1, sd1, fi1, fe1, b1}), 32'(exp_ctl(rem1)));
`ifdef HAZARD_PERF_EN
            chk("perf_stall_lat3", ps3, m_ps3);
            chk("perf_stall_lat1", ps1, m_ps1);
            chk("perf_flush_lat3", pf3, m_pf);
            chk("perf_flush_lat1", pf1, m_pf);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fwd_wr = '0;
        ex_is_load = 0;
        ex_rd_wr = 0;
        id_rs_used = '0;
        redirect = 0;
    endtask

    task automatic load_use();
        ex_is_load = 1;
        ex_rd_wr = 1;
        ex_rd = 5'd7;
        id_rs_addr = {5'd7, 5'd0};
        id_rs_used = 2'b10;
    endtask

    initial begin
        // Reset, with a matching producer that must not forward.
        rst_n = 0;
        fwd_wr = 3'b111;
        fwd_rd = {5'd5, 5'd5, 5'd5};
        ex_rs_addr = {5'd0, 5'd5};
        cyc();
        cyc();
        @(negedge clk);
        chk("reset_fwd_sel", 32'(sel3), 32'd0);
        chk("reset_busy", 32'(b3), 32'd0);

        // Priority: youngest producer first, then the next one.
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("t1_fwd_youngest", 32'(sel3[1:0]), 32'd1);
        cyc();
        fwd_wr = 3'b110;
        @(negedge clk);
        chk("t1_fwd_second", 32'(sel3[1:0]), 32'd2);

        // x0 never forwards.
        cyc();
        fwd_wr = 3'b001;
        fwd_rd = {5'd5, 5'd5, 5'd0};
        ex_rs_addr = '0;
        @(negedge clk);
        chk("t2_x0_no_fwd", 32'(sel3[1:0]), 32'd0);

        // Load-use: three stall cycles on LD_LAT=3, one on LD_LAT=1.
        cyc();
        idle_in();
        load_use();
        @(negedge clk);
        chk("t3_c1_stall", 32'({si3, sd3, fe3, b3}), 32'b1110);
        chk("t3_c1_lat1", 32'({si1, b1}), 32'b10);
        cyc();
        idle_in();
        @(negedge clk);
        chk("t3_c2_stall", 32'({si3, sd3, fe3, b3}), 32'b1111);
        chk("t3_c2_lat1", 32'({si1, b1}), 32'b00);
        cyc();
        @(negedge clk);
        chk("t3_c3_stall", 32'({si3, sd3, fe3, b3}), 32'b1111);
        cyc();
        @(negedge clk);
        chk("t3_c4_idle", 32'({si3, sd3, fe3, b3}), 32'b0000);

        // Redirect in the second stall cycle wins.
        cyc();
        load_use();
        cyc();
        idle_in();
        redirect = 1;
        @(negedge clk);
        chk("t4_redirect", 32'({si3, sd3, fi3, fe3}), 32'b0011);
        cyc();
        redirect = 0;
        @(negedge clk);
        chk("t4_after", 32'({si3, b3}), 32'b00);

        // No stall if the port is unused or the load targets x0.
        cyc();
        load_use();
        id_rs_used = 2'b00;
        @(negedge clk);
        chk("t5_unused", 32'(si3), 32'd0);
        cyc();
        load_use();
        ex_rd = 5'd0;
        id_rs_addr = '0;
        id_rs_used = 2'b11;
        @(negedge clk);
        chk("t5_x0_load", 32'(si3), 32'd0);

        // Reset in the middle of a stall.
        cyc();
        load_use();
        cyc();
        idle_in();
        rst_n = 0;
        @(negedge clk);
        chk("t6_in_reset", 32'({si3, sd3, fi3, fe3, b3}), 32'd0);
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("t6_released", 32'({si3, b3}), 32'b00);
`ifdef HAZARD_PERF_EN
        chk("t6_perf_stall_zero", ps3, 32'd0);
        chk("t6_perf_flush_zero", pf3, 32'd0);
        cyc();
        load_use();
        cyc();
        idle_in();
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_perf_stall_lat", ps3, 32'd3);
`endif

        // Random traffic over a small register window to force matches.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst_n = ($urandom_range(0, 63) != 0);
            redirect = ($urandom_range(0, 7) == 0);
            fwd_wr = 3'($urandom);
            for (int j = 0; j < 3; j++)
                fwd_rd[j*5 +: 5] = 5'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                ex_rs_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
                id_rs_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
            end
            id_rs_used = 2'($urandom);
            ex_is_load = 1'($urandom);
            ex_rd_wr = ($urandom_range(0, 3) != 0);
            ex_rd = 5'($urandom_range(0, 3));
        end

        cyc();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
